piece_randomizer: RTL

PIECE_RANDOMIZER -- requirements
Module: piece_randomizer

---
 rtl/piece_randomizer.sv | 137 +++++++++++++
 1 files changed

// File: rtl/piece_randomizer.sv
// rtl/piece_randomizer.sv - 7-bag style piece randomizer with LFSR draws and a preview queue
// Draws fill a PREVIEW_DEPTH+1 queue; a bag mask forbids repeats inside each NUM_PIECES group.
module piece_randomizer #(
  parameter int          NUM_PIECES    = 7,
  parameter int          WIDTH         = 3,
  parameter int          PREVIEW_DEPTH = 3,
  parameter logic [15:0] SEED          = 16'hACE1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             next,
  input  logic                             seed_load,
  input  logic [15:0]                      seed_in,
  output logic [WIDTH-1:0]                 piece,
  output logic [PREVIEW_DEPTH*WIDTH-1:0]   preview,
  output logic                             valid
);

  localparam int QLEN = PREVIEW_DEPTH + 1;
  localparam int CW   = $clog2(QLEN + 1);
  localparam logic [WIDTH-1:0]      NP_W  = WIDTH'(NUM_PIECES);
  localparam logic [WIDTH-1:0]      ONE_W = WIDTH'(1);
  localparam logic [CW-1:0]         FULL  = CW'(QLEN);
  localparam logic [CW-1:0]         LAST  = CW'(PREVIEW_DEPTH);
  localparam logic [15:0]           TAPS  = 16'hB400;

  typedef enum logic [1:0] {
    ST_READY,
    ST_START,
    ST_SEARCH
  } state_t;

  state_t                state_q, state_d;
  logic [15:0]           lfsr_q, lfsr_d;
  logic [WIDTH-1:0]      cand_q, cand_d;
  logic [CW-1:0]         count_q, count_d;
  logic [NUM_PIECES-1:0] bag_q, bag_d;
  logic [WIDTH-1:0]      queue_q [QLEN];
  logic [WIDTH-1:0]      queue_d [QLEN];

  logic [WIDTH-1:0]      lfsr_low;
  logic [WIDTH-1:0]      start_cand;
  logic [NUM_PIECES-1:0] cand_onehot;
  logic                  cand_used;

  // Out-of-range LFSR samples fold to code 1 so the search always starts on a legal code.
  always_comb begin
    lfsr_low    = lfsr_q[WIDTH-1:0];
    start_cand  = ((lfsr_low != '0) && (lfsr_low <= NP_W)) ? lfsr_low : ONE_W;
    cand_onehot = {{(NUM_PIECES-1){1'b0}}, 1'b1} << (cand_q - ONE_W);
    cand_used   = |(bag_q & cand_onehot);
  end

  always_comb begin
    lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : 16'h0000);
    if (seed_load) begin
      lfsr_d = (seed_in != 16'h0000) ? seed_in : SEED;
    end
  end

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    count_d = count_q;
    bag_d   = bag_q;
    for (int i = 0; i < QLEN; i++) begin
      queue_d[i] = queue_q[i];
    end

    case (state_q)
      ST_START: begin
        cand_d  = start_cand;
        if (&bag_q) begin
          bag_d = '0;
        end
        state_d = ST_SEARCH;
      end
      ST_SEARCH: begin
        if (!cand_used) begin
          for (int i = 0; i < QLEN; i++) begin
            if (count_q == CW'(i)) begin
              queue_d[i] = cand_q;
            end
          end
          bag_d   = bag_q | cand_onehot;
          count_d = count_q + CW'(1);
          state_d = (count_q == LAST) ? ST_READY : ST_START;
        end else begin
          cand_d = (cand_q == NP_W) ? ONE_W : cand_q + ONE_W;
        end
      end
      ST_READY: begin
        if (next) begin
          for (int i = 0; i < QLEN - 1; i++) begin
            queue_d[i] = queue_q[i+1];
          end
          queue_d[QLEN-1] = '0;
          count_d = count_q - CW'(1);
          state_d = ST_START;
        end
      end
      default: begin
        state_d = ST_START;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_START;
      lfsr_q  <= SEED;
      cand_q  <= ONE_W;
      count_q <= '0;
      bag_q   <= '0;
      for (int i = 0; i < QLEN; i++) begin
        queue_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      cand_q  <= cand_d;
      count_q <= count_d;
      bag_q   <= bag_d;
      for (int i = 0; i < QLEN; i++) begin
        queue_q[i] <= queue_d[i];
      end
    end
  end

  assign valid = (count_q == FULL);
  assign piece = queue_q[0];

  for (genvar g = 0; g < PREVIEW_DEPTH; g++) begin : g_preview
    assign preview[g*WIDTH +: WIDTH] = queue_q[g+1];
  end

endmodule
